// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through, runs byte/half/word
// loads and stores over a single-outstanding req/ack bus, stalls until done.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stall_req,
    output logic        align_err,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [31:0]   load_buf;
    logic [CW-1:0] cnt;
    logic          timed_out;

    logic          is_load, is_store, is_mem, is_unsigned, misaligned, timeout_hit;
    size_t         size;
    logic [3:0]    sel_nxt;
    logic [31:0]   wdata_nxt, lane, load_val;

    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_unsigned = 1'b0;
        size        = SZ_WORD;
        case (mem_op_i)
            4'd1: begin is_load = 1'b1; size = SZ_BYTE; end
            4'd2: begin is_load = 1'b1; size = SZ_BYTE; is_unsigned = 1'b1; end
            4'd3: begin is_load = 1'b1; size = SZ_HALF; end
            4'd4: begin is_load = 1'b1; size = SZ_HALF; is_unsigned = 1'b1; end
            4'd5: begin is_load = 1'b1; size = SZ_WORD; end
            4'd6: begin is_store = 1'b1; size = SZ_BYTE; end
            4'd7: begin is_store = 1'b1; size = SZ_HALF; end
            4'd8: begin is_store = 1'b1; size = SZ_WORD; end
            default: ;
        endcase
        is_mem     = is_load | is_store;
        misaligned = ((size == SZ_HALF) && mem_addr_i[0]) ||
                     ((size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00));
    end

    // Little-endian lane enables and replicated store data
    always_comb begin
        case (size)
            SZ_BYTE: begin
                sel_nxt   = 4'b0001 << mem_addr_i[1:0];
                wdata_nxt = {4{mem_sdata_i[7:0]}};
            end
            SZ_HALF: begin
                sel_nxt   = 4'b0011 << mem_addr_i[1:0];
                wdata_nxt = {2{mem_sdata_i[15:0]}};
            end
            default: begin
                sel_nxt   = 4'b1111;
                wdata_nxt = mem_sdata_i;
            end
        endcase
    end

    // Inputs are held stable during the access, so the address still selects the lane in DONE
    always_comb begin
        lane = load_buf >> {mem_addr_i[1:0], 3'b000};
        case (size)
            SZ_BYTE: load_val = is_unsigned ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            SZ_HALF: load_val = is_unsigned ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_val = load_buf;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST) && !dbus_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'h0;
            dbus_sel   <= 4'h0;
            dbus_wdata <= 32'h0;
            load_buf   <= 32'h0;
            cnt        <= '0;
            timed_out  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (is_mem && !misaligned) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_addr  <= {mem_addr_i[31:2], 2'b00};
                        dbus_sel   <= sel_nxt;
                        dbus_wdata <= wdata_nxt;
                        cnt        <= '0;
                        timed_out  <= 1'b0;
                    end
                end
                BUS: begin
                    cnt <= cnt + CW'(1);
                    if (dbus_ack) begin
                        load_buf <= dbus_rdata;
                        dbus_req <= 1'b0;
                    end else if (timeout_hit) begin
                        dbus_req  <= 1'b0;
                        timed_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        wb_wd     = mem_wd_i;
        wb_wreg   = 1'b0;
        wb_wdata  = 32'h0;
        stall_req = 1'b0;
        align_err = 1'b0;
        bus_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!is_mem) begin
                    wb_wreg  = mem_wreg_i;
                    wb_wdata = mem_wdata_i;
                end else if (misaligned) begin
                    align_err = 1'b1;
                    wb_wdata  = mem_wdata_i;
                end else begin
                    stall_req = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                stall_req = 1'b1;
                if (dbus_ack || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                bus_err   = timed_out;
                state_nxt = IDLE;
                if (is_load && !timed_out) begin
                    wb_wreg  = mem_wreg_i;
                    wb_wdata = load_val;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            wb_wd     = 5'h0;
            wb_wreg   = 1'b0;
            wb_wdata  = 32'h0;
            stall_req = 1'b0;
            align_err = 1'b0;
            bus_err   = 1'b0;
        end
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the 5-stage CPU pipeline, placed between the EX/MEM pipeline register and the MEM/WB register.
- Passes ALU results straight through.
- Executes loads and stores (byte, halfword, word) over a single-outstanding req/ack data bus.
- Stalls the pipeline until the bus transaction completes, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255, maximum BUS-state cycles without dbus_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_wd_i  in  5  destination register address from EX/MEM
- mem_wreg_i  in  1  register write enable from EX/MEM
- mem_wdata_i  in  32  ALU result from EX/MEM
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- mem_addr_i  in  32  effective byte address
- mem_sdata_i  in  32  store data (rt)
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  1 = write, registered
- dbus_addr  out  32  word address {mem_addr_i[31:2],2'b00}, registered
- dbus_sel  out  4  byte-lane enables, registered
- dbus_wdata  out  32  write data, lane-replicated, registered
- dbus_rdata  in  32  read data, valid when dbus_ack=1
- dbus_ack  in  1  transaction complete
- wb_wd  out  5  destination address to MEM/WB
- wb_wreg  out  1  write enable to MEM/WB
- wb_wdata  out  32  write-back data to MEM/WB
- stall_req  out  1  stall request to pipeline control
- align_err  out  1  misaligned access, one-cycle pulse
- bus_err  out  1  bus timeout, one-cycle pulse

Behaviour:
- Reset values: state=IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0, load buffer=0, timeout counter=0.
  - Combinational outputs during reset: wb_wd=0, wb_wreg=0, wb_wdata=0, stall_req=0, align_err=0, bus_err=0.
- Upstream contract: EX/MEM holds all inputs stable while stall_req=1.
- FSM states: IDLE, BUS, DONE.
- IDLE, op NONE:
  - wb_* = mem_*_i (combinational pass-through).
  - stall_req=0; stay in IDLE.
- IDLE, memory op, misaligned:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - align_err=1, wb_wreg=0, stall_req=0, no bus request; stay in IDLE.
- IDLE, memory op, aligned:
  - stall_req=1 (combinational).
  - Register dbus_req=1, dbus_we, dbus_addr, dbus_sel, dbus_wdata; go to BUS.
- Lane mapping (little-endian):
  - Byte: sel = 0001 << addr[1:0]; wdata = {4{sdata[7:0]}}.
  - Half: sel = 0011 << addr[1:0]; wdata = {2{sdata[15:0]}}.
  - Word: sel = 1111; wdata = sdata.
- BUS:
  - stall_req=1; bus outputs held constant; counter increments each cycle.
  - On dbus_ack: capture dbus_rdata into the load buffer, clear dbus_req, go to DONE.
  - On timeout (counter = TIMEOUT-1 with no ack, TIMEOUT!=0): clear dbus_req, bus_err=1 for one cycle, go to DONE with the load suppressed.
  - Ack arriving in the first BUS cycle means dbus_req is high for exactly one cycle.
- DONE:
  - stall_req=0; wb_wd=mem_wd_i.
  - Load: wb_wreg=mem_wreg_i; wb_wdata is the extracted lane (LB/LH sign-extend, LBU/LHU zero-extend, LW whole word).
  - Store or timed-out access: wb_wreg=0, wb_wdata=0.
  - Go to IDLE unconditionally. The next instruction is evaluated in the following cycle, so back-to-back memory ops each take ≥3 cycles.
- Latency: memory op with 0 wait states takes 3 cycles (IDLE, BUS, DONE); each wait state adds 1 cycle.
- Reset during BUS: next edge forces IDLE with dbus_req=0; any later ack is ignored in IDLE.
- dbus_ack while in IDLE or DONE: ignored.

Test Plan:
- op NONE, wd=3, wreg=1, wdata=0x12345678 -> same cycle wb_wd=3, wb_wreg=1, wb_wdata=0x12345678; stall_req=0; dbus_req never asserted.
- LW addr=0x100, ack in first BUS cycle, rdata=0xDEADBEEF:
  - dbus_req high 1 cycle, addr=0x100, sel=1111, we=0.
  - stall_req high 2 cycles; DONE gives wb_wdata=0xDEADBEEF, wb_wreg=1.
- LB addr=0x203, rdata=0x80FFFFFF, 2 wait states -> sel=1000; wb_wdata=0xFFFFFF80. The same sequence with LBU -> wb_wdata=0x00000080. Total 5 cycles.
- SH addr=0x302, sdata=0x0000ABCD -> dbus_we=1, sel=1100, wdata=0xABCDABCD, addr=0x300; DONE wb_wreg=0.
- LW addr=0x101 -> align_err=1 for 1 cycle, wb_wreg=0, stall_req=0, no dbus_req.
- TIMEOUT=4, no ack -> dbus_req high 4 cycles, bus_err pulse, wb_wreg=0. Repeat with rst asserted in the 2nd BUS cycle -> IDLE, dbus_req=0 next cycle, late ack ignored.
